// File: rtl/usart_rx_fifo_core_pkg.sv
// rtl/usart_rx_fifo_core_pkg.sv - shared types and helpers for the USART receive path
package usart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [1:0] {
    CL_5 = 2'b00,
    CL_6 = 2'b01,
    CL_7 = 2'b10,
    CL_8 = 2'b11
  } char_len_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [3:0] data_bits(input char_len_e cl);
    logic [1:0] c;
    c = cl;
    return 4'd5 + {2'b00, c};
  endfunction

  // Encoding 11 is a second "no parity" code, folded onto PAR_NONE.
  function automatic parity_e to_parity(input logic [1:0] p);
    case (p)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// rtl/usart_rx_fifo.sv - show-ahead receive FIFO of rx_entry_t
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rx_entry_t     push_data,
  input  logic          pop,
  output rx_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  rx_entry_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign count    = count_q;
  assign head     = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/usart_rx_fifo_core.sv
// rtl/usart_rx_fifo_core.sv - USART receiver: synchroniser, tick generator, frame FSM, FIFO
module usart_rx_fifo_core
  import usart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIV_W-1:0]                   baud_div_i,
  input  logic [1:0]                         char_len_i,
  input  logic [1:0]                         parity_i,
  input  logic                               stop2_i,
  input  logic                               rxd_i,
  input  logic                               rd_en_i,
  output logic [7:0]                         rd_data_o,
  output logic                               rd_perr_o,
  output logic                               rd_ferr_o,
  output logic                               rd_valid_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
  output logic                               overrun_o,
  input  logic                               overrun_clr_i
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic             sync1, sync2, rx_prev;
  logic             rx_s, fall;
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;
  logic [TW-1:0]    tcnt;
  logic             samp;
  rx_state_e        state;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [3:0]       nbits;
  parity_e          par_mode;
  logic             stop2_q;
  logic             perr_q;
  logic             ferr_q;
  logic [7:0]       data_al;
  logic             par_calc;
  logic             push;
  rx_entry_t        push_entry;
  rx_entry_t        head;
  logic             fifo_full, fifo_empty, fifo_ovf;

  assign rx_s = sync2;
  assign fall = rx_prev && !rx_s;
  assign tick = (baud_cnt >= baud_div_i);
  assign samp = tick && (tcnt == ((state == ST_START) ? HALF_LAST : FULL_LAST));

  // Bits were shifted in from the top, so right-align to the frame's length.
  assign data_al  = shreg >> (4'd8 - nbits);
  assign par_calc = (^data_al) ^ rx_s;

  assign push = samp && ((state == ST_STOP2) || (state == ST_STOP1 && !stop2_q));
  assign push_entry = '{ferr: ferr_q | ~rx_s, perr: perr_q, data: data_al};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
      baud_cnt <= '0;
      tcnt     <= '0;
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      nbits    <= 4'd8;
      par_mode <= PAR_NONE;
      stop2_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1   <= rxd_i;
      sync2   <= sync1;
      rx_prev <= sync2;

      // Restarting the divider on the start edge centres every later sample.
      if ((state == ST_IDLE && fall) || tick) baud_cnt <= '0;
      else                                    baud_cnt <= baud_cnt + 1'b1;

      if (state == ST_IDLE) tcnt <= '0;
      else if (tick)        tcnt <= samp ? '0 : tcnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (samp) begin
            if (!rx_s) begin
              state    <= ST_DATA;
              nbits    <= data_bits(char_len_e'(char_len_i));
              par_mode <= to_parity(parity_i);
              stop2_q  <= stop2_i;
              bit_idx  <= '0;
              shreg    <= '0;
              perr_q   <= 1'b0;
              ferr_q   <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (samp) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if ({1'b0, bit_idx} == nbits - 4'd1)
              state <= (par_mode != PAR_NONE) ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (samp) begin
            perr_q <= (par_mode == PAR_EVEN) ? par_calc : ~par_calc;
            state  <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (samp) begin
            ferr_q <= ~rx_s;
            state  <= stop2_q ? ST_STOP2 : ST_IDLE;
          end
        end
        ST_STOP2: begin
          if (samp) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)               overrun_o <= 1'b0;
    else if (fifo_ovf)      overrun_o <= 1'b1;
    else if (overrun_clr_i) overrun_o <= 1'b0;
  end

  usart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (rd_en_i),
    .head      (head),
    .count     (count_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

  assign rd_data_o  = head.data;
  assign rd_perr_o  = head.perr;
  assign rd_ferr_o  = head.ferr;
  assign rd_valid_o = !fifo_empty;

endmodule
